operand_entry_ctrl: RTL and testbench
=====================================

# operand_entry_ctrl

Sequencer for two-operand entry from the board's slide switches and a pushbutton. It debounces the ENTER and CLEAR pushbuttons and captures switch values into operand registers `in1` then `in2`. It presents the completed pair to the downstream arithmetic/LCD path with a valid/ready handshake. It sits between the raw board I/O and the operand consumers, and replaces free-running switch capture with an explicit, ordered entry sequence.

## Interface
- `DEB_CYCLES`, 16: consecutive stable synchronized samples required before a debounced level changes (min 2).
- `OPW`, 3: operand width in bits.
- `CNTW`, 8: transaction counter width.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high; sampled on rising `clk`.
- `buttons`  in  4  slide switches, asynchronous; `[OPW-1:0]` = operand value, `[3]` unused by this block.
- `enter`  in  1  raw ENTER pushbutton, asynchronous, active-high.
- `clear`  in  1  raw CLEAR pushbutton, asynchronous, active-high.
- `op_ready`  in  1  consumer accepts the pair this cycle.
- `in1`  out  OPW  first operand, registered.
- `in2`  out  OPW  second operand, registered.
- `op_valid`  out  1  pair `in1`/`in2` complete and held stable.
- `phase`  out  2  entry prompt for the LCD: 0 = ENTER_A, 1 = ENTER_B, 2 = ISSUE. Value 3 is never driven.
- `txn_count`  out  CNTW  count of accepted pairs.

## Operation
- Each pushbutton goes through one `btn_debounce` instance in three stages:
  - 2-flop synchronizer.
  - Stability counter: the debounced level takes the synchronized value after it has held for `DEB_CYCLES` consecutive cycles. Any mismatch restarts the count.
  - Rising-edge detect: produces a one-cycle pulse, `enter_p` or `clear_p`.
- Switch sync: `buttons[OPW-1:0]` pass through a 2-flop synchronizer. Captures use the synchronized value.
- FSM states and transitions:
  - ENTER_A: on `enter_p`, `in1` <= switches, go to ENTER_B.
  - ENTER_B: on `enter_p`, `in2` <= switches, `op_valid` <= 1, go to ISSUE.
  - ISSUE: `op_valid`=1. `in1`/`in2` are frozen. `enter_p` is ignored. When `op_valid && op_ready`: `op_valid` <= 0, `txn_count` <= `txn_count`+1, go to ENTER_A.
- `clear_p`, from any state: go to ENTER_A, `op_valid` <= 0. `in1`/`in2` keep their values so the LCD still shows the last entry.
- Priority, highest first: `reset` > `clear_p` > handshake/capture.
- Simultaneous events:
  - `clear_p` together with a handshake in ISSUE: the handshake completes. `txn_count` increments, because the consumer already took the pair. Next state is ENTER_A.
  - `clear_p` together with `enter_p`: clear wins and no operand is captured.
- `txn_count` wraps modulo 2^CNTW: 255 -> 0 at the default width.
- `op_ready` is ignored outside ISSUE.
- `reset` mid-operation: everything below is forced to its reset value next edge, including debounce counters, debounced levels and synchronizers (cleared to 0). Any pending pulse is discarded.
- Reset values: `in1`=0, `in2`=0, `op_valid`=0, `phase`=0, `txn_count`=0, state ENTER_A.

## Timing
- Button press to pulse: a clean edge on `enter` yields `enter_p` 2 (sync) + `DEB_CYCLES` + 1 (edge) cycles later. One pulse per press. Release produces no pulse.
- `in1`/`in2` update on the edge after `enter_p` is high.
- `op_valid` rises in the same cycle `in2` updates.
- Handshake: a transfer occurs in a cycle where `op_valid`=1 and `op_ready`=1. `op_valid` drops on the next edge, `phase` returns to 0 and `txn_count` updates.
- `op_valid` never deasserts without a transfer, except by `clear_p` or `reset`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `operand_entry_pkg`: state encoding (ENTER_A=0, ENTER_B=1, ISSUE=2), phase constants, default `OPW`. `phase` is the state register driven directly.
- Sub-module `btn_debounce` (params `DEB_CYCLES`). Ports: `clk`, `reset`, `btn_raw` -> `level`, `rise_p`. Instantiated twice, for ENTER and CLEAR.
- Top holds the switch synchronizer, FSM, operand registers and counter.

## Test plan
Bench runs with `DEB_CYCLES`=4.
- Reset release -> all outputs 0, `phase`=0. A 3-cycle ENTER glitch produces no pulse and `in1` stays 0.
- Switches=5, press ENTER; switches=3, press ENTER -> `in1`=5 one edge after the first pulse, then `in2`=3 and `op_valid`=1 together, `phase`=2.
- Hold `op_ready`=0 for 20 cycles while toggling switches and pressing ENTER -> `in1`=5, `in2`=3, `op_valid`=1 unchanged. Then `op_ready`=1 for one cycle -> `op_valid`=0, `txn_count`=1, `phase`=0.
- CLEAR in ENTER_B after `in1`=6 -> `phase`=0, `in1` still 6. The next ENTER overwrites `in1`.
- Force `clear_p` and a handshake in the same cycle -> `txn_count` increments, `phase`=0. Force `clear_p` and `enter_p` together in ENTER_A -> no capture.
- Complete 256 transactions -> `txn_count` wraps to 0. Assert `reset` while in ISSUE -> all outputs reset values next edge.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry sequencer.
package operand_entry_pkg;

    // Default operand width in bits.
    localparam int OPW_DEF = 3;

    // The FSM state encoding also serves as the LCD prompt on the phase port.
    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_ISSUE   = 2'd2
    } state_t;

    localparam logic [1:0] PH_ENTER_A = 2'd0;
    localparam logic [1:0] PH_ENTER_B = 2'd1;
    localparam logic [1:0] PH_ISSUE   = 2'd2;

endpackage

// File: rtl/operand_entry_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, and a
// registered rising-edge pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise_p
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;

    // Synchronize, filter, and edge-detect; everything clears on reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], btn_raw};
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            if (r_sync[1] == r_level) begin
                // Input agrees with the filtered level: restart the count.
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                // Held the new value for DEB_CYCLES samples: accept it.
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level  = r_level;
    assign rise_p = r_rise;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Ordered two-operand entry from slide switches with ENTER/CLEAR buttons,
// presenting the captured pair downstream through a valid/ready handshake.
module operand_entry_ctrl
    import operand_entry_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int OPW        = OPW_DEF,
    parameter int CNTW       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      buttons,
    input  logic            enter,
    input  logic            clear,
    input  logic            op_ready,
    output logic [OPW-1:0]  in1,
    output logic [OPW-1:0]  in2,
    output logic            op_valid,
    output logic [1:0]      phase,
    output logic [CNTW-1:0] txn_count
);

    logic            w_enter_p;
    logic            w_clear_p;
    logic            w_enter_lvl;
    logic            w_clear_lvl;
    logic [2:0]      w_unused;

    logic [OPW-1:0]  r_sw_s0;
    logic [OPW-1:0]  r_sw_s1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OPW-1:0]  r_in1;
    logic [OPW-1:0]  w_in1_nxt;
    logic [OPW-1:0]  r_in2;
    logic [OPW-1:0]  w_in2_nxt;
    logic            r_op_valid;
    logic            w_op_valid_nxt;
    logic [CNTW-1:0] r_txn;
    logic [CNTW-1:0] w_txn_nxt;
    logic            w_xfer;

    // Switch bit 3 and the debounced levels are not needed by this block.
    assign w_unused = {buttons[3], w_enter_lvl, w_clear_lvl};

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (enter),
        .level   (w_enter_lvl),
        .rise_p  (w_enter_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (clear),
        .level   (w_clear_lvl),
        .rise_p  (w_clear_p)
    );

    // Bring the asynchronous switch levels into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s0 <= '0;
            r_sw_s1 <= '0;
        end else begin
            r_sw_s0 <= buttons[OPW-1:0];
            r_sw_s1 <= r_sw_s0;
        end
    end

    // A transfer only counts while the pair is actually being offered.
    assign w_xfer = (r_state == ST_ISSUE) && r_op_valid && op_ready;

    // Next-state, operand capture and counter update; clear overrides capture
    // but never cancels a transfer the consumer has already taken.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_in1_nxt      = r_in1;
        w_in2_nxt      = r_in2;
        w_op_valid_nxt = r_op_valid;
        w_txn_nxt      = r_txn;
        if (w_xfer) begin
            w_txn_nxt = r_txn + 1'b1;
        end
        if (w_clear_p) begin
            w_state_nxt    = ST_ENTER_A;
            w_op_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_ENTER_A: begin
                    if (w_enter_p) begin
                        w_in1_nxt   = r_sw_s1;
                        w_state_nxt = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (w_enter_p) begin
                        w_in2_nxt      = r_sw_s1;
                        w_op_valid_nxt = 1'b1;
                        w_state_nxt    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_xfer) begin
                        w_op_valid_nxt = 1'b0;
                        w_state_nxt    = ST_ENTER_A;
                    end
                end
                default: begin
                    w_state_nxt    = ST_ENTER_A;
                    w_op_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state, operand registers, valid flag and transaction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ENTER_A;
            r_in1      <= '0;
            r_in2      <= '0;
            r_op_valid <= 1'b0;
            r_txn      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in1      <= w_in1_nxt;
            r_in2      <= w_in2_nxt;
            r_op_valid <= w_op_valid_nxt;
            r_txn      <= w_txn_nxt;
        end
    end

    assign in1       = r_in1;
    assign in2       = r_in2;
    assign op_valid  = r_op_valid;
    assign phase     = r_state;
    assign txn_count = r_txn;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl with a pair scoreboard.
module tb_operand_entry_ctrl;

    localparam int DEB = 4;
    // Posedges from a raw press until the FSM has acted on the pulse.
    localparam int P   = DEB + 4;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } pair_t;

    logic       clk;
    logic       reset;
    logic [3:0] buttons;
    logic       enter;
    logic       clear;
    logic       op_ready;
    logic [2:0] in1;
    logic [2:0] in2;
    logic       op_valid;
    logic [1:0] phase;
    logic [7:0] txn_count;

    int n_checks;
    int n_fail;

    pair_t      sb[$];
    logic [2:0] exp_in1;
    logic [2:0] exp_in2;
    logic [1:0] exp_phase;
    logic [7:0] exp_txn;

    operand_entry_ctrl #(
        .DEB_CYCLES (DEB),
        .OPW        (3),
        .CNTW       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .buttons   (buttons),
        .enter     (enter),
        .clear     (clear),
        .op_ready  (op_ready),
        .in1       (in1),
        .in2       (in2),
        .op_valid  (op_valid),
        .phase     (phase),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".in1"},   in1,       exp_in1);
        check({tag, ".in2"},   in2,       exp_in2);
        check({tag, ".phase"}, phase,     exp_phase);
        check({tag, ".valid"}, op_valid,  exp_phase == 2'd2);
        check({tag, ".txn"},   txn_count, exp_txn);
    endtask

    // Compare the offered pair against the scoreboard head.
    task automatic sb_compare(input string tag);
        pair_t p;
        check({tag, ".sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            p = sb.pop_front();
            check({tag, ".sb_in1"}, in1, p.a);
            check({tag, ".sb_in2"}, in2, p.b);
        end
    endtask

    // Press (and release) ENTER and/or CLEAR with switches at sw. When
    // ready_at_pulse is set, op_ready is raised exactly in the pulse cycle.
    task automatic press(input string tag, input logic [2:0] sw, input logic do_enter,
                         input logic do_clear, input logic ready_at_pulse);
        buttons = {1'b0, sw};
        enter   = do_enter;
        clear   = do_clear;
        repeat (P - 1) @(negedge clk);
        // One edge before the pulse is consumed nothing may have moved.
        check_outputs({tag, ".pre"});
        if (ready_at_pulse) begin
            op_ready = 1'b1;
            if (exp_phase == 2'd2) begin
                sb_compare(tag);
                exp_txn   = exp_txn + 8'd1;
                exp_phase = 2'd0;
            end
        end
        if (do_clear) begin
            exp_phase = 2'd0;
        end else if (do_enter) begin
            if (exp_phase == 2'd0) begin
                exp_in1   = sw;
                exp_phase = 2'd1;
            end else if (exp_phase == 2'd1) begin
                exp_in2   = sw;
                exp_phase = 2'd2;
                sb.push_back('{a: exp_in1, b: sw});
            end
        end
        @(negedge clk);
        op_ready = 1'b0;
        check_outputs({tag, ".post"});
        enter = 1'b0;
        clear = 1'b0;
        repeat (P) @(negedge clk);
    endtask

    // One-cycle op_ready while the pair is offered.
    task automatic handshake(input string tag);
        op_ready = 1'b1;
        check({tag, ".valid_before"}, op_valid, 1);
        sb_compare(tag);
        @(negedge clk);
        op_ready  = 1'b0;
        exp_txn   = exp_txn + 8'd1;
        exp_phase = 2'd0;
        check_outputs({tag, ".after"});
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        buttons   = 4'd0;
        enter     = 1'b0;
        clear     = 1'b0;
        op_ready  = 1'b0;
        exp_in1   = '0;
        exp_in2   = '0;
        exp_phase = '0;
        exp_txn   = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs("reset");

        // Short glitch must be filtered out.
        enter = 1'b1;
        repeat (3) @(negedge clk);
        enter = 1'b0;
        repeat (P + 2) @(negedge clk);
        check_outputs("glitch");

        // Basic pair entry; pre-checks also pin down the pulse latency.
        press("a5", 3'd5, 1'b1, 1'b0, 1'b0);
        press("b3", 3'd3, 1'b1, 1'b0, 1'b0);

        // Stall the consumer while switches and ENTER are exercised.
        for (int i = 0; i < 20; i++) begin
            buttons = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("hold.valid", op_valid, 1);
        end
        press("hold_enter", 3'd1, 1'b1, 1'b0, 1'b0);
        check("hold.in1", in1, 5);
        check("hold.in2", in2, 3);
        handshake("hs1");

        // CLEAR in ENTER_B keeps in1 visible, next ENTER overwrites it.
        press("a6", 3'd6, 1'b1, 1'b0, 1'b0);
        press("clr_b", 3'd4, 1'b0, 1'b1, 1'b0);
        check("clr_b.in1_kept", in1, 6);
        press("a2", 3'd2, 1'b1, 1'b0, 1'b0);

        // CLEAR coincident with a handshake: transfer still counts.
        press("b7", 3'd7, 1'b1, 1'b0, 1'b0);
        press("clr_hs", 3'd0, 1'b0, 1'b1, 1'b1);

        // CLEAR coincident with ENTER in ENTER_A: nothing captured.
        press("clr_ent", 3'd7, 1'b1, 1'b1, 1'b0);

        // Run the counter all the way round.
        while (exp_txn != 8'd0) begin
            press("wa", 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);
            press("wb", 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);
            handshake("wrap_hs");
        end
        check("wrap.txn_zero", txn_count, 0);

        // One more transaction, then reset while the next pair is offered.
        press("ra", 3'd1, 1'b1, 1'b0, 1'b0);
        press("rb", 3'd2, 1'b1, 1'b0, 1'b0);
        handshake("pre_rst_hs");
        press("sa", 3'd6, 1'b1, 1'b0, 1'b0);
        press("sb", 3'd5, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_in1   = '0;
        exp_in2   = '0;
        exp_phase = '0;
        exp_txn   = '0;
        sb.delete();
        check_outputs("mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
